air_channel: RTL and testbench

Parametrised N-node shared radio medium for multi-node WSN simulation and FPGA emulation, replacing point-to-point antenna cross-wiring between SoC instances. Each node drives a transmit enable and bit; the block combines them as a wired-OR medium, delays the result by a fixed propagation latency, and delivers it to every non-transmitting node. It flags and counts collisions, and optionally injects pseudo-random bit errors. It sits between the `txrx` front ends of N `soc_tb` instances.

---
 rtl/air_channel_pkg.sv | 45 ++++
 rtl/air_channel_lfsr16.sv | 39 +++
 rtl/air_channel.sv | 172 +++++++++++++++++
 tb/tb_air_channel.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/air_channel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : air_channel_pkg
//  Description : Shared constants, types and helpers for the air_channel
//                shared radio medium: LFSR tap mask, default seed,
//                parameter range limits, the per-stage medium flag struct,
//                a multi-hot detector and the Galois LFSR step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package air_channel_pkg;

    // Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] c_lfsr_taps    = 16'hB400;
    localparam logic [15:0] c_default_seed = 16'hACE1;

    // Legal parameter ranges
    localparam int c_nodes_min = 2;
    localparam int c_nodes_max = 8;
    localparam int c_delay_min = 1;
    localparam int c_delay_max = 64;
    localparam int c_ber_min   = 1;
    localparam int c_ber_max   = 15;
    localparam int c_cnt_w_min = 4;
    localparam int c_cnt_w_max = 32;

    // Medium flags carried down the delay line next to the source mask
    typedef struct packed {
        logic col;   // two or more transmitters
        logic car;   // any transmitter
        logic data;  // wired-OR of the enabled transmit bits
    } medium_t;

    // True when two or more bits of v are set: clearing the lowest set bit
    // leaves something behind only if another bit was set.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    // One right-shifting Galois step: feed the LSB back through the taps.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? c_lfsr_taps : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/air_channel_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : air_lfsr16
//  Description : 16-bit free-running Galois LFSR used as the channel noise
//                source. Loads the seed on reset (a zero seed would lock the
//                register, so it is replaced by the default seed) and then
//                advances one step every clock.
//  Ports       : clk   - system clock
//                reset - synchronous, active-low reset
//                seed  - value loaded on reset
//                state - current LFSR contents
//  Revision    : 1.0 - initial release
// ============================================================================
module air_lfsr16
    import air_channel_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] r_state;
    logic [15:0] w_seed;

    assign w_seed = (seed == 16'h0000) ? c_default_seed : seed;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= w_seed;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/air_channel.sv
`default_nettype none
// ============================================================================
//  Module      : air_channel
//  Description : N-node shared radio medium. Transmitters are combined as a
//                wired-OR, delayed by DELAY clock cycles and delivered to
//                every node that was not itself transmitting. Collisions are
//                flagged and counted; optional pseudo-random bit errors are
//                injected on the delayed carrier and counted.
//  Macro       : AIR_CHANNEL_NOISE_EN - builds the LFSR noise source and the
//                error counter. Undefined: no noise, err_cnt tied to 0.
//  Ports       : clk           - system clock
//                reset         - synchronous, active-low reset
//                tx_en         - per-node transmit enable
//                tx_bit        - per-node transmit bit (ignored if not enabled)
//                rx_valid      - carrier present at node i (not its own)
//                rx_bit        - received bit at node i, 0 without carrier
//                collision     - two or more transmitters, delayed
//                cnt_clr       - synchronous clear of both counters
//                collision_cnt - saturating count of collision events
//                err_cnt       - saturating count of injected bit errors
//  Revision    : 1.0 - initial release
// ============================================================================
module air_channel
    import air_channel_pkg::*;
#(
    parameter int          N_NODES   = 2,
    parameter int          DELAY     = 4,
    parameter int          BER_SHIFT = 4,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_NODES-1:0] tx_en,
    input  logic [N_NODES-1:0] tx_bit,
    output logic [N_NODES-1:0] rx_valid,
    output logic [N_NODES-1:0] rx_bit,
    output logic               collision,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   collision_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int               c_stage_w = $bits(medium_t) + N_NODES;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter range check
    // ------------------------------------------------------------------
    if ((N_NODES < c_nodes_min) || (N_NODES > c_nodes_max) ||
        (DELAY < c_delay_min)   || (DELAY > c_delay_max)   ||
        (BER_SHIFT < c_ber_min) || (BER_SHIFT > c_ber_max) ||
        (CNT_W < c_cnt_w_min)   || (CNT_W > c_cnt_w_max)   ||
        ($bits(SEED) != 16)) begin : g_param_check
        $error("air_channel: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Medium combine
    // ------------------------------------------------------------------
    medium_t                 w_medium_in;
    logic [c_stage_w-1:0]    w_stage_in;

    always_comb begin
        w_medium_in      = '0;
        w_medium_in.data = |(tx_en & tx_bit);
        w_medium_in.car  = |tx_en;
        w_medium_in.col  = multi_hot(8'(tx_en));
    end

    assign w_stage_in = {w_medium_in, tx_en};

    // ------------------------------------------------------------------
    // Propagation delay line; the last stage is the output stage. Reset
    // clears every stage so nothing sampled before reset can emerge later.
    // ------------------------------------------------------------------
    logic [c_stage_w-1:0] r_pipe [DELAY];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DELAY; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int k = 1; k < DELAY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    medium_t            w_d_med;
    logic [N_NODES-1:0] w_d_src;

    assign {w_d_med, w_d_src} = r_pipe[DELAY-1];

    // ------------------------------------------------------------------
    // Noise source: a single flip shared by all receivers
    // ------------------------------------------------------------------
    logic w_flip;

`ifdef AIR_CHANNEL_NOISE_EN
    localparam logic [15:0] c_ber_mask = 16'((32'd1 << BER_SHIFT) - 32'd1);

    logic [15:0]      w_lfsr_state;
    logic [CNT_W-1:0] r_err_cnt;

    air_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .state (w_lfsr_state)
    );

    assign w_flip = ((w_lfsr_state & c_ber_mask) == 16'h0000);

    // Counted whenever a carrier is on the air, listener or not
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_flip && w_d_med.car && (r_err_cnt != c_cnt_max)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign w_flip  = 1'b0;
    assign err_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Delivery: half-duplex, a transmitter never hears itself
    // ------------------------------------------------------------------
    assign rx_valid  = {N_NODES{w_d_med.car}} & ~w_d_src;
    assign rx_bit    = rx_valid & {N_NODES{w_d_med.data ^ w_flip}};
    assign collision = w_d_med.col;

    // ------------------------------------------------------------------
    // Collision event counter: counts rising edges of the delayed flag so
    // a multi-cycle collision registers once.
    // ------------------------------------------------------------------
    logic             r_col_prev;
    logic             w_col_rise;
    logic [CNT_W-1:0] r_collision_cnt;

    assign w_col_rise = w_d_med.col & ~r_col_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col_prev <= 1'b0;
        end else begin
            r_col_prev <= w_d_med.col;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_collision_cnt <= '0;
        end else if (cnt_clr) begin
            r_collision_cnt <= '0;
        end else if (w_col_rise && (r_collision_cnt != c_cnt_max)) begin
            r_collision_cnt <= r_collision_cnt + 1'b1;
        end
    end

    assign collision_cnt = r_collision_cnt;

endmodule
`default_nettype wire

// File: tb/tb_air_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_air_channel
//  Description : Self-checking bench for air_channel. Two instances
//                (A: 3 nodes, DELAY 4, 4-bit counters; B: 2 nodes, DELAY 1,
//                16-bit counters, zero seed) are driven by directed and
//                random traffic and compared every cycle with a history-
//                based reference model of the medium.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_air_channel;

    localparam int NA  = 3;
    localparam int DA  = 4;
    localparam int WA  = 4;
    localparam int NB  = 2;
    localparam int DB  = 1;
    localparam int WB  = 16;
    localparam int HSZ = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [NA-1:0] tx_en_a, tx_bit_a, rx_valid_a, rx_bit_a;
    logic          col_a, clr_a;
    logic [WA-1:0] ccnt_a, ecnt_a;
    logic [NB-1:0] tx_en_b, tx_bit_b, rx_valid_b, rx_bit_b;
    logic          col_b, clr_b;
    logic [WB-1:0] ccnt_b, ecnt_b;

    air_channel #(.N_NODES(NA), .DELAY(DA), .BER_SHIFT(1), .CNT_W(WA), .SEED(16'hACE1)) u_dut_a (
        .clk(clk), .reset(reset), .tx_en(tx_en_a), .tx_bit(tx_bit_a),
        .rx_valid(rx_valid_a), .rx_bit(rx_bit_a), .collision(col_a),
        .cnt_clr(clr_a), .collision_cnt(ccnt_a), .err_cnt(ecnt_a));

    air_channel #(.N_NODES(NB), .DELAY(DB), .BER_SHIFT(1), .CNT_W(WB), .SEED(16'h0000)) u_dut_b (
        .clk(clk), .reset(reset), .tx_en(tx_en_b), .tx_bit(tx_bit_b),
        .rx_valid(rx_valid_b), .rx_bit(rx_bit_b), .collision(col_b),
        .cnt_clr(clr_b), .collision_cnt(ccnt_b), .err_cnt(ecnt_b));

    // Reference model state: input history per instance, indexed by edge
    logic [2:0] h_en  [2][HSZ];
    logic [2:0] h_bit [2][HSZ];
    int         cyc;
    int         rst_cyc;
    int         cc     [2];
    int         ccmax  [2];
    bit         col_now  [2];
    bit         col_prev [2];
    int         checks;
    int         errors;
    int         mism;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Medium seen at the output of instance d right after edge cyc: the
    // input sampled DELAY-1 edges earlier, or silence if that predates reset.
    task automatic expect_at(input int d, output logic [2:0] src, output logic bt,
                             output logic car, output logic col);
        int j;
        j = cyc - ((d == 0) ? DA : DB) + 1;
        if (j <= rst_cyc) begin
            src = 3'b000; bt = 1'b0; car = 1'b0; col = 1'b0;
        end else begin
            src = h_en[d][j % HSZ];
            bt  = |(src & h_bit[d][j % HSZ]);
            car = (src != 3'b000);
            col = ($countones(src) >= 2);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] s;
        logic       b, c, k;
        logic [2:0] ev;
        logic       any;
        // ---- instance A
        expect_at(0, s, b, c, k);
        ev = {3{c}} & ~s;
        chk("rx_valid_a", 32'(rx_valid_a), 32'(ev));
`ifdef AIR_CHANNEL_NOISE_EN
        any = |(rx_bit_a & ev);
        chk("rx_bit_a_idle",  32'(rx_bit_a & ~ev), 32'd0);
        chk("rx_bit_a_agree", 32'(rx_bit_a), 32'(ev & {3{any}}));
`else
        any = 1'b0;
        chk("rx_bit_a",   32'(rx_bit_a), 32'(ev & {3{b}}));
        chk("err_cnt_a",  32'(ecnt_a), 32'd0);
`endif
        chk("collision_a", 32'(col_a), 32'(k));
        chk("ccnt_a",      32'(ccnt_a), 32'(cc[0]));
        // ---- instance B
        expect_at(1, s, b, c, k);
        ev = {3{c}} & ~s;
        chk("rx_valid_b", 32'(rx_valid_b), 32'(ev[1:0]));
`ifdef AIR_CHANNEL_NOISE_EN
        any = |(rx_bit_b & ev[1:0]);
        chk("rx_bit_b_idle",  32'(rx_bit_b & ~ev[1:0]), 32'd0);
        chk("rx_bit_b_agree", 32'(rx_bit_b), 32'(ev[1:0] & {2{any}}));
`else
        chk("rx_bit_b",   32'(rx_bit_b), 32'(ev[1:0] & {2{b}}));
        chk("err_cnt_b",  32'(ecnt_b), 32'd0);
`endif
        chk("collision_b", 32'(col_b), 32'(k));
        chk("ccnt_b",      32'(ccnt_b), 32'(cc[1]));
        if (ev[1] && (rx_bit_b[1] !== b)) mism++;
    endtask

    task automatic tick();
        logic [2:0] s;
        logic       b, c, k;
        logic       clr;
        @(posedge clk);
        cyc++;
        h_en [0][cyc % HSZ] = tx_en_a;
        h_bit[0][cyc % HSZ] = tx_bit_a;
        h_en [1][cyc % HSZ] = {1'b0, tx_en_b};
        h_bit[1][cyc % HSZ] = {1'b0, tx_bit_b};
        if (!reset) rst_cyc = cyc;
        for (int d = 0; d < 2; d++) begin
            clr = (d == 0) ? clr_a : clr_b;
            if (!reset) begin
                cc[d] = 0; col_now[d] = 1'b0; col_prev[d] = 1'b0;
            end else begin
                if (clr) cc[d] = 0;
                else if (col_now[d] && !col_prev[d] && (cc[d] < ccmax[d])) cc[d]++;
                col_prev[d] = col_now[d];
                expect_at(d, s, b, c, k);
                col_now[d] = k;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        tx_en_a = '0; tx_bit_a = '0; tx_en_b = '0; tx_bit_b = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [3:0] pat;
        checks = 0; errors = 0; mism = 0;
        cyc = 0; rst_cyc = 0;
        ccmax[0] = (1 << WA) - 1;
        ccmax[1] = (1 << WB) - 1;
        cc[0] = 0; cc[1] = 0;
        col_now[0] = 0; col_now[1] = 0; col_prev[0] = 0; col_prev[1] = 0;
        reset = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        tx_en_a = '0; tx_bit_a = '0; tx_en_b = '0; tx_bit_b = '0;

        // Reset state
        idle(3);
        reset = 1'b1;
        idle(2);

        // Basic delivery: node 0 sends 1,0,1,1
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            tx_en_a = 3'b001; tx_bit_a = {2'b00, pat[i]};
            tx_en_b = 2'b01;  tx_bit_b = {1'b0, pat[i]};
            tick();
        end
        idle(DA + 2);

        // Collision: nodes 0 and 1 send 1 and 0 for three cycles
        for (int i = 0; i < 3; i++) begin
            tx_en_a = 3'b011; tx_bit_a = 3'b001;
            tx_en_b = 2'b11;  tx_bit_b = 2'b01;
            tick();
        end
        idle(DA + 2);
        chk("ccnt_a_one_event", 32'(ccnt_a), 32'd1);

        // Reset during the second bit of an 8-bit burst
        for (int i = 0; i < 8; i++) begin
            tx_en_a = 3'b101; tx_bit_a = 3'($urandom);
            tx_en_b = 2'b01;  tx_bit_b = 2'($urandom);
            reset = (i == 1) ? 1'b0 : 1'b1;
            tick();
            if (i == 1) begin
                chk("rx_valid_a_in_reset", 32'(rx_valid_a), 32'd0);
                chk("ccnt_a_in_reset",     32'(ccnt_a), 32'd0);
                reset = 1'b1;
                break;
            end
        end
        idle(DA + 2);

        // Random traffic with occasional counter clears
        for (int i = 0; i < 400; i++) begin
            tx_en_a  = 3'($urandom); tx_bit_a = 3'($urandom);
            tx_en_b  = 2'($urandom); tx_bit_b = 2'($urandom);
            clr_a    = ($urandom_range(0, 15) == 0);
            clr_b    = ($urandom_range(0, 15) == 0);
            tick();
        end
        clr_a = 1'b0; clr_b = 1'b0;
        idle(DA + 2);

        // Saturation: 20 separate collisions on a 4-bit counter
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tx_en_a = 3'b110; tx_bit_a = 3'($urandom);
            tick();
            idle(2);
        end
        idle(DA + 2);
        chk("ccnt_a_saturated", 32'(ccnt_a), 32'd15);

        // Clear coincident with a new collision edge
        tx_en_a = 3'b011; tx_bit_a = 3'b011;
        tick();
        idle(DA - 1);
        chk("collision_a_high", 32'(col_a), 32'd1);
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        chk("ccnt_a_clr_wins", 32'(ccnt_a), 32'd0);
        idle(2);
        chk("ccnt_a_after_clr", 32'(ccnt_a), 32'd0);

        // Noise run on B: 1000 carrier cycles from node 0, node 1 listening
        idle(3);
        mism = 0;
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tx_en_a = '0; tx_bit_a = '0;
            tx_en_b = 2'b01; tx_bit_b = {1'b0, 1'($urandom)};
            tick();
        end
        idle(DB + 3);
`ifdef AIR_CHANNEL_NOISE_EN
        chk("err_cnt_b_low",  32'(ecnt_b >= 16'd400), 32'd1);
        chk("err_cnt_b_high", 32'(ecnt_b <= 16'd600), 32'd1);
        chk("err_cnt_b_vs_mismatch", 32'(ecnt_b), 32'(mism));
`else
        chk("err_cnt_b_off",  32'(ecnt_b), 32'd0);
        chk("mismatch_b_off", 32'(mism), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
